// File: rtl/imuldiv_pkg.sv
// Shared definitions for the iterative imuldiv units.
package imuldiv_pkg;

    // Encoding of the iterative-unit control FSM
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Request function select: operand interpretation
    localparam logic FN_UNSIGNED = 1'b0;
    localparam logic FN_SIGNED   = 1'b1;

endpackage

// File: rtl/imuldiv_mul_iter_param_ctrl.sv
// Control for the iterative multiplier: FSM, iteration counter, val/rdy and datapath strobes.
module imuldiv_mul_iter_param_ctrl
    import imuldiv_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic mulreq_val,
    input  logic mulresp_rdy,
    output logic mulreq_rdy,
    output logic mulresp_val,
    output logic load,
    output logic step,
    output logic finish
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state, counter update and handshake/strobe decode
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        load        = 1'b0;
        step        = 1'b0;
        finish      = 1'b0;
        // Ready is held low while reset is asserted so nothing is accepted then
        mulreq_rdy  = (state == ST_IDLE) && !reset;
        mulresp_val = (state == ST_DONE);
        case (state)
            ST_IDLE: begin
                if (mulreq_val && mulreq_rdy) begin
                    load       = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                step = 1'b1;
                if (cnt == CNT_LAST) begin
                    finish     = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            ST_DONE: begin
                if (mulresp_rdy) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/imuldiv_mul_iter_param.sv
// Iterative shift-add multiplier, R multiplier bits per cycle, signed/unsigned per request.
module imuldiv_mul_iter_param
    import imuldiv_pkg::*;
#(
    parameter int unsigned W = 32,
    parameter int unsigned R = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     mulreq_msg_a,
    input  logic [W-1:0]     mulreq_msg_b,
    input  logic             mulreq_msg_fn,
    input  logic             mulreq_val,
    output logic             mulreq_rdy,
    output logic [2*W-1:0]   mulresp_msg_result,
    output logic             mulresp_val,
    input  logic             mulresp_rdy
);

    localparam int unsigned N  = W / R;
    localparam int unsigned PW = 2 * W;

    logic            load;
    logic            step;
    logic            finish;

    logic [PW-1:0]   a_reg;
    logic [W-1:0]    b_reg;
    logic            neg;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   result;

    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;
    logic            neg_in;
    logic [PW-1:0]   acc_next;
    logic [PW-1:0]   prod_fix;

    imuldiv_mul_iter_param_ctrl #(
        .N (N)
    ) u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .mulreq_val  (mulreq_val),
        .mulresp_rdy (mulresp_rdy),
        .mulreq_rdy  (mulreq_rdy),
        .mulresp_val (mulresp_val),
        .load        (load),
        .step        (step),
        .finish      (finish)
    );

    // Operand magnitudes and result sign; -2^(W-1) maps to 2^(W-1) as unsigned W-bit
    always_comb begin
        a_mag  = mulreq_msg_a;
        b_mag  = mulreq_msg_b;
        if (mulreq_msg_fn == FN_SIGNED && mulreq_msg_a[W-1]) begin
            a_mag = ~mulreq_msg_a + W'(1);
        end
        if (mulreq_msg_fn == FN_SIGNED && mulreq_msg_b[W-1]) begin
            b_mag = ~mulreq_msg_b + W'(1);
        end
        neg_in = (mulreq_msg_fn == FN_SIGNED) && (mulreq_msg_a[W-1] ^ mulreq_msg_b[W-1]);
    end

    // R gated adds of the shifted multiplicand, then the sign fixup for the final step
    always_comb begin
        acc_next = acc;
        for (int i = 0; i < int'(R); i++) begin
            if (b_reg[i]) begin
                acc_next = acc_next + (a_reg << i);
            end
        end
        prod_fix = neg ? (~acc_next + PW'(1)) : acc_next;
    end

    // Datapath registers; everything holds outside load/step so DONE is frozen
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg  <= '0;
            b_reg  <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            result <= '0;
        end else if (load) begin
            a_reg  <= {{W{1'b0}}, a_mag};
            b_reg  <= b_mag;
            neg    <= neg_in;
            acc    <= '0;
        end else if (step) begin
            acc    <= acc_next;
            a_reg  <= a_reg << R;
            b_reg  <= b_reg >> R;
            if (finish) begin
                result <= prod_fix;
            end
        end
    end

    assign mulresp_msg_result = result;

endmodule

// File: doc/imuldiv_mul_iter_param.md
Name: imuldiv_mul_iter_param

Overview:
Parametrised iterative integer multiplier for the imuldiv unit. It takes W-bit operands and produces a full 2W-bit product. It retires R multiplier bits per cycle using shift-add, and selects signed or unsigned mode per request. It sits behind the same val/rdy request/response interfaces as the other imuldiv units and holds one operation in flight.

Parameters:
W, 32, operand width; W >= 2
R, 1, multiplier bits retired per cycle; one of 1, 2, 4, 8; W % R == 0
N (local), W/R, compute cycles per operation

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
mulreq_msg_a  in  W  operand A (multiplicand)
mulreq_msg_b  in  W  operand B (multiplier)
mulreq_msg_fn  in  1  1 = signed (two's complement), 0 = unsigned
mulreq_val  in  1  request valid
mulreq_rdy  out  1  request ready
mulresp_msg_result  out  2W  product
mulresp_val  out  1  response valid
mulresp_rdy  in  1  response ready

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high; all state updates on posedge clk.
- Reset values: state = IDLE; mulresp_val = 0; mulresp_msg_result = 0; counter = 0. mulreq_rdy = 0 while reset is high and 1 in the first cycle after reset deasserts.
- FSM states: IDLE, CALC, DONE.
- IDLE: mulreq_rdy = 1 (combinational on state only, not on mulreq_val).
  - On mulreq_val & mulreq_rdy, latch the following and go to CALC:
    - a_reg = {W'b0, |a|}
    - b_reg = |b|
    - neg = fn & (a[W-1] ^ b[W-1])
    - acc = 0, cnt = 0
  - In unsigned mode the magnitude is the raw operand. Signed magnitude of -2^(W-1) is 2^(W-1), which is valid as unsigned W-bit.
- CALC: mulreq_rdy = 0. Each cycle:
  - acc += a_reg * b_reg[R-1:0], computed as R gated adds of shifted a_reg (no W×W multiplier).
  - a_reg <<= R; b_reg >>= R; cnt++.
  - When cnt == N-1, go to DONE. The result register gets neg ? -(acc_next) : acc_next, in 2W-bit two's complement.
- DONE: mulresp_val = 1 and the result is held stable.
  - On mulresp_rdy, go to IDLE.
  - No same-cycle accept of a new request: mulreq_rdy stays 0 in DONE.
- Latency: request accepted in cycle 0; CALC occupies cycles 1..N; mulresp_val is first high in cycle N+1. Examples: W=32, R=1 gives cycle 33; W=32, R=4 gives cycle 9. No early termination; latency is independent of data.
- Throughput: one operation per N+2 cycles at best (accept, N CALC, at least 1 DONE).
- Backpressure: mulresp_val, mulresp_msg_result, and all internal state are frozen in DONE until mulresp_rdy. mulreq_val is ignored outside IDLE.
- Arithmetic:
  - The product is exact in 2W bits for all inputs in both modes; no overflow is possible.
  - Signed -2^(W-1) × -2^(W-1) = 2^(2W-2).
- Reset mid-operation (CALC or DONE): the next state is IDLE, mulresp_val drops in the cycle after reset is sampled, and the in-flight operation is discarded with no response.
- mulresp_msg_result is driven only from the result register; it is 0 after reset and otherwise holds the last product.

Decomposition:
- Shared package imuldiv_pkg:
  - FSM state encoding (IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2)
  - fn constants FN_UNSIGNED = 1'b0 and FN_SIGNED = 1'b1, reused by the future iterative divider
- One sub-module, imuldiv_mul_iter_param_ctrl: FSM, counter (width $clog2(N)), and the val/rdy outputs. It outputs load/step/finish strobes.
- Datapath registers, magnitude logic, R-bit add tree, and sign fixup stay in the top module.

Test Plan:
- W=32, R=1, unsigned, a=0xFFFFFFFF, b=0xFFFFFFFF -> result 0xFFFFFFFE00000001; mulresp_val first high exactly 33 cycles after accept; mulreq_rdy low in cycles 1..33.
- W=32, R=1, signed, a=0xFFFFFFFD (-3), b=7 -> 0xFFFFFFFFFFFFFFEB (-21).
- W=32, R=1, signed corner cases:
  - a=b=0x80000000 -> 0x4000000000000000
  - a=0x80000000, b=1 -> 0xFFFFFFFF80000000
  - a=0, b=0x80000000 -> 0
- Backpressure: hold mulresp_rdy=0 for 5 cycles after mulresp_val rises, with mulreq_val=1 throughout -> result and mulresp_val stable, no second accept; mulreq_rdy=1 in the cycle after the response handshake.
- W=32, R=4, unsigned:
  - 1000 × 1000 -> 0xF4240
  - 0x10000 × 0x10000 -> 0x100000000
  - val first high 9 cycles after accept
  - back-to-back requests produce correct results in order.
- Reset at cycle 10 of a CALC -> mulresp_val=0 and mulreq_rdy=1 after reset drops, no spurious response; a following 6×7 unsigned request returns 42.
